// File: rtl/sdf_bf_stage.sv
// Radix-2 single-delay-feedback butterfly stage: fills a feedback line in phase 0, butterflies against it in phase 1.
// Optional SDF_BF_SCALE_EN: output register loads the result halved (arithmetic shift right by 1).
module sdf_bf_stage #(
    parameter int DW    = 16,
    parameter int DELAY = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] din_re,
    input  logic signed [DW-1:0] din_im,
    input  logic [CNT_W-1:0]     cnt_ctrl,
    output logic                 valid_out,
    output logic signed [DW:0]   dout_re,
    output logic signed [DW:0]   dout_im
);
    localparam int SB = $clog2(DELAY);
    localparam int AW = DW + 1;

    logic signed [AW-1:0] line_re_q [DELAY];
    logic signed [AW-1:0] line_im_q [DELAY];
    logic signed [AW-1:0] line_re_d [DELAY];
    logic signed [AW-1:0] line_im_d [DELAY];
    logic                 primed_q, primed_d;
    logic                 valid_out_q, valid_out_d;
    logic signed [AW-1:0] dout_re_q, dout_re_d;
    logic signed [AW-1:0] dout_im_q, dout_im_d;

    logic                 sel;
    logic signed [AW-1:0] fb_re, fb_im, din_re_x, din_im_x;
    logic signed [AW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [AW-1:0] res_re, res_im, out_re, out_im;
    logic                 unused_cnt;

    assign unused_cnt = ^cnt_ctrl;

    always_comb begin
        sel      = cnt_ctrl[SB];
        fb_re    = line_re_q[DELAY-1];
        fb_im    = line_im_q[DELAY-1];
        din_re_x = {din_re[DW-1], din_re};
        din_im_x = {din_im[DW-1], din_im};
        // fb holds a DW-bit-range sample in phase 1, so DW+1 bits cannot overflow
        sum_re   = fb_re + din_re_x;
        sum_im   = fb_im + din_im_x;
        dif_re   = fb_re - din_re_x;
        dif_im   = fb_im - din_im_x;
        res_re   = sel ? sum_re : fb_re;
        res_im   = sel ? sum_im : fb_im;
`ifdef SDF_BF_SCALE_EN
        out_re   = res_re >>> 1;
        out_im   = res_im >>> 1;
`else
        out_re   = res_re;
        out_im   = res_im;
`endif

        line_re_d = line_re_q;
        line_im_d = line_im_q;
        if (valid_in) begin
            for (int i = DELAY - 1; i > 0; i--) begin
                line_re_d[i] = line_re_q[i-1];
                line_im_d[i] = line_im_q[i-1];
            end
            line_re_d[0] = sel ? dif_re : din_re_x;
            line_im_d[0] = sel ? dif_im : din_im_x;
        end

        primed_d    = primed_q | (valid_in & sel);
        // phase-0 output before the first butterfly would only be reset zeros
        valid_out_d = valid_in & (sel | primed_q);
        dout_re_d   = valid_out_d ? out_re : dout_re_q;
        dout_im_d   = valid_out_d ? out_im : dout_im_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                line_re_q[i] <= '0;
                line_im_q[i] <= '0;
            end
            primed_q    <= 1'b0;
            valid_out_q <= 1'b0;
            dout_re_q   <= '0;
            dout_im_q   <= '0;
        end else begin
            line_re_q   <= line_re_d;
            line_im_q   <= line_im_d;
            primed_q    <= primed_d;
            valid_out_q <= valid_out_d;
            dout_re_q   <= dout_re_d;
            dout_im_q   <= dout_im_d;
        end
    end

    assign valid_out = valid_out_q;
    assign dout_re   = dout_re_q;
    assign dout_im   = dout_im_q;
endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage (DW=16, DELAY=16); expected outputs queued as samples are driven.
module tb_sdf_bf_stage;
    localparam int DW    = 16;
    localparam int DELAY = 16;
    localparam int CNT_W = 5;

    typedef struct {
        logic signed [DW:0] re;
        logic signed [DW:0] im;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 valid_in;
    logic signed [DW-1:0] din_re, din_im;
    logic [CNT_W-1:0]     cnt_ctrl;
    logic                 valid_out;
    logic signed [DW:0]   dout_re, dout_im;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    sdf_bf_stage #(.DW(DW), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .din_re   (din_re),
        .din_im   (din_im),
        .cnt_ctrl (cnt_ctrl),
        .valid_out(valid_out),
        .dout_re  (dout_re),
        .dout_im  (dout_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sc(input int v);
`ifdef SDF_BF_SCALE_EN
        return v >>> 1;
`else
        return v;
`endif
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic signed [DW:0] obs, input logic signed [DW:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input int re, input int im, input int cnt, input logic exp_v);
        exp_t e;
        logic [31:0] r, i, c;
        r = re; i = im; c = cnt;
        @(negedge clk);
        valid_in = v;
        din_re   = r[DW-1:0];
        din_im   = i[DW-1:0];
        cnt_ctrl = c[CNT_W-1:0];
        @(posedge clk);
        #1;
        chk_bit("valid_out", valid_out, exp_v);
        if (exp_v) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL scoreboard: observed valid output expected none queued");
            end else begin
                e = q.pop_front();
                chk_val("dout_re", dout_re, e.re);
                chk_val("dout_im", dout_im, e.im);
            end
        end
    endtask

    task automatic step_exp(input int re, input int im, input int cnt, input int ere, input int eim);
        exp_t e;
        logic [31:0] a, b;
        a = sc(ere); b = sc(eim);
        e.re = a[DW:0];
        e.im = b[DW:0];
        q.push_back(e);
        step(1'b1, re, im, cnt, 1'b1);
    endtask

    task automatic chk_zero_out(input string tag);
        chk_val({tag, "_re"}, dout_re, '0);
        chk_val({tag, "_im"}, dout_im, '0);
    endtask

    task automatic first_frame();
        for (int n = 0; n < 32; n++) begin
            if (n < 16) step(1'b1, n, 0, n, 1'b0);
            else        step_exp(n, 0, n, 2*n - 16, 0);
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; din_re = '0; din_im = '0; cnt_ctrl = '0;

        // reset held with live phase-1 input: rst must win
        for (int k = 0; k < 2; k++) begin
            step(1'b1, int'($urandom), int'($urandom), 16 + k, 1'b0);
            chk_zero_out("rst_dout");
        end
        rst = 1'b0;
        step(1'b0, 0, 0, 0, 1'b0);
        chk_zero_out("post_rst_dout");

        first_frame();

        // drain of stored differences (-16) then zero butterflies
        for (int n = 0; n < 32; n++) begin
            if (n < 16) step_exp(0, 0, n, -16, 0);
            else        step_exp(0, 0, n, 0, 0);
        end

        // extremes
        for (int n = 0; n < 32; n++) begin
            if (n < 16) step_exp(-32768, -32768, n, 0, 0);
            else        step_exp(-32768, -32768, n, -65536, -65536);
        end

        // ramp with negated imaginary part; phase 0 shows the zero extreme differences
        for (int n = 0; n < 32; n++) begin
            if (n < 16) step_exp(n, -n, n, 0, 0);
            else        step_exp(n, -n, n, 2*n - 16, 16 - 2*n);
        end

        // gap at frame boundary: valid drops, output holds
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 99, 99, k, 1'b0);
            chk_val("gap_hold_re", dout_re, 17'(sc(46)));
            chk_val("gap_hold_im", dout_im, 17'(sc(-46)));
        end

        // resume: stored differences (-16, +16) emitted
        for (int n = 0; n < 32; n++) begin
            if (n < 16) step_exp(0, 0, n, -16, 16);
            else        step_exp(0, 0, n, 0, 0);
        end

        // partial frame then mid-frame reset
        for (int n = 0; n < 20; n++) begin
            if (n < 16) step_exp(5, 5, n, 0, 0);
            else        step_exp(5, 5, n, 10, 10);
        end
        rst = 1'b1;
        step(1'b1, 7, 7, 20, 1'b0);
        chk_zero_out("midrst_dout");
        rst = 1'b0;

        // post-reset phase 0 suppressed again
        first_frame();

        n_cmp++;
        assert (q.size() == 0) else begin
            n_bad++;
            $error("FAIL queue_empty: observed %0d left expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
